// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Gathers the registered results of the Arith, Logic, CMP and Shift units,
//   tags each with its source unit and queues it in a DEPTH-entry circular
//   buffer. The oldest entry is presented first-word-fall-through on a
//   valid/ready interface. Full back-pressures issue upstream.
//
// Ports
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   <unit>_OUT/_Flag   unit result and its valid strobe (Carry_OUT for Arith)
//   Out_Ready          consumer accepts the head entry
//   ALU_OUT/Carry/Unit_Tag  head entry, all zero when Out_Valid = 0
//   Out_Valid          FIFO not empty
//   Count/Full/Empty   registered occupancy
//   Overflow           sticky: a result was dropped because the FIFO was full
//   Multi_Flag_Err     sticky: more than one unit flag seen in one cycle
module alu_result_fifo #(
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [OUT_WIDTH-1:0]       Arith_OUT,
  input  logic                       Carry_OUT,
  input  logic                       Arith_Flag,
  input  logic [OUT_WIDTH-1:0]       Logic_OUT,
  input  logic                       Logic_Flag,
  input  logic [OUT_WIDTH-1:0]       CMP_OUT,
  input  logic                       CMP_Flag,
  input  logic [OUT_WIDTH-1:0]       SHIFT_OUT,
  input  logic                       SHIFT_Flag,
  input  logic                       Out_Ready,
  output logic [OUT_WIDTH-1:0]       ALU_OUT,
  output logic                       Carry,
  output logic [1:0]                 Unit_Tag,
  output logic                       Out_Valid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Overflow,
  output logic                       Multi_Flag_Err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = OUT_WIDTH + 3;

  // Entry layout: {carry, tag[1:0], result}
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             multi_err_q, multi_err_d;

  logic [3:0]           flags;
  logic                 push_req;
  logic                 multi;
  logic                 pop;
  logic                 push_ok;
  logic [OUT_WIDTH-1:0] sel_data;
  logic [1:0]           sel_tag;
  logic                 sel_carry;
  logic [ENTRY_W-1:0]   head;

  always_comb begin
    flags    = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    push_req = |flags;
    // Clearing the lowest set bit leaves something only if two or more flags are set.
    multi    = |(flags & (flags - 4'd1));

    sel_data  = SHIFT_OUT;
    sel_tag   = 2'b11;
    sel_carry = 1'b0;
    if (Arith_Flag) begin
      sel_data  = Arith_OUT;
      sel_tag   = 2'b00;
      sel_carry = Carry_OUT;
    end else if (Logic_Flag) begin
      sel_data = Logic_OUT;
      sel_tag  = 2'b01;
    end else if (CMP_Flag) begin
      sel_data = CMP_OUT;
      sel_tag  = 2'b10;
    end

    pop = !empty_q && Out_Ready;
    // When full, wr_ptr == rd_ptr; a same-cycle pop frees the very slot being written.
    push_ok = push_req && (!full_q || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {sel_carry, sel_tag, sel_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    full_d      = (count_d == CNT_W'(DEPTH));
    empty_d     = (count_d == '0);
    overflow_d  = overflow_q || (push_req && full_q && !pop);
    multi_err_d = multi_err_q || multi;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      multi_err_q <= multi_err_d;
    end
  end

  // Storage needs no reset: pointers and Empty gate everything visible.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    Out_Valid = !empty_q;
    ALU_OUT   = '0;
    Unit_Tag  = '0;
    Carry     = 1'b0;
    if (!empty_q) begin
      ALU_OUT  = head[OUT_WIDTH-1:0];
      Unit_Tag = head[OUT_WIDTH+1:OUT_WIDTH];
      Carry    = head[OUT_WIDTH+2];
    end
    Count          = count_q;
    Full           = full_q;
    Empty          = empty_q;
    Overflow       = overflow_q;
    Multi_Flag_Err = multi_err_q;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Collects the registered results of the four ALU units (Arith, Logic, CMP, Shift), selected by the one-hot unit enables from the ALU function decoder. Each valid result is tagged with the unit that produced it and queued in a small FIFO. Results are presented to the downstream consumer through a valid/ready handshake. The block sits directly downstream of the units in ALU_TOP and replaces the bare output mux; it back-pressures issue through Full.

## Interface
- OUT_WIDTH, 16, width of every unit result and of ALU_OUT
- DEPTH, 4, FIFO entries; power of two, ≥2

- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- Arith_OUT  in  OUT_WIDTH  arithmetic unit result
- Carry_OUT  in  1  arithmetic carry/borrow
- Arith_Flag  in  1  Arith_OUT valid this cycle
- Logic_OUT  in  OUT_WIDTH  logic unit result
- Logic_Flag  in  1  Logic_OUT valid this cycle
- CMP_OUT  in  OUT_WIDTH  compare unit result
- CMP_Flag  in  1  CMP_OUT valid this cycle
- SHIFT_OUT  in  OUT_WIDTH  shift unit result
- SHIFT_Flag  in  1  SHIFT_OUT valid this cycle
- Out_Ready  in  1  consumer accepts head entry
- ALU_OUT  out  OUT_WIDTH  head entry result
- Carry  out  1  head entry carry (0 for non-arith)
- Unit_Tag  out  2  head entry source: 00 Arith, 01 Logic, 10 CMP, 11 Shift (matches ALU_FUN[3:2])
- Out_Valid  out  1  head entry valid
- Count  out  $clog2(DEPTH)+1  entries held
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- Overflow  out  1  sticky: result dropped because FIFO full
- Multi_Flag_Err  out  1  sticky: more than one unit flag in same cycle

## Operation
- Push request = OR of the four unit flags.
- Source selection is by fixed priority Arith > Logic > CMP > Shift. The selected result, its tag, and its carry are the push data; carry is Carry_OUT for Arith and 0 otherwise.
- Two or more flags asserted in one cycle: push only the highest-priority result and set Multi_Flag_Err.
- Storage: circular buffer of DEPTH entries, each {Carry, Unit_Tag, result}. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately.
- Pop = Out_Valid & Out_Ready.
- Push while Full without a same-cycle pop: the entry is dropped, Overflow is set, and pointers and Count are unchanged.
- Push while Full with a same-cycle pop: the push is accepted and Count stays DEPTH.
- Push and pop in the same cycle when not full and not empty: both are performed and Count is unchanged.
- Out_Ready while Empty: ignored.
- Out_Valid = !Empty.
- ALU_OUT, Carry, and Unit_Tag are forced to 0 when Out_Valid = 0. Otherwise they show the head entry (first-word-fall-through).
- Overflow and Multi_Flag_Err are cleared only by RST.
- Order is strict FIFO; no reordering by unit.

## Timing
- Reset (RST high at a CLK edge) sets:
  - pointers and Count to 0
  - Empty = 1; Full, Out_Valid, Overflow, Multi_Flag_Err = 0
  - ALU_OUT, Carry, Unit_Tag = 0
- RST mid-operation discards all queued entries. A flag in the reset cycle is not pushed.
- Latency: a result flagged in cycle N appears at the outputs with Out_Valid = 1 in cycle N+1 when the FIFO was empty. Otherwise it appears behind the older entries.
- Pop at edge N: the next entry (or all-zero with Out_Valid = 0) is shown in cycle N+1.
- Count, Full, and Empty are registered and consistent with the stored entries in the same cycle.
- Throughput: one push and one pop per cycle are sustained indefinitely with no bubbles.
- Overflow and Multi_Flag_Err assert in the cycle after the offending edge.
- Upstream must hold off issue while Full. Since units have one-cycle latency, one in-flight result may still arrive and triggers Overflow if no pop occurs.

## Test plan
- Reset then idle: Count = 0, Empty = 1, Out_Valid = 0, ALU_OUT = 0, both sticky flags 0.
- Single push: Arith_Flag with Arith_OUT = 16'h00F0, Carry_OUT = 1, Out_Ready = 0.
  - Next cycle: Out_Valid = 1, ALU_OUT = 00F0, Carry = 1, Unit_Tag = 00, Count = 1.
  - Then Out_Ready = 1 for one cycle: Empty = 1 and outputs return to 0.
- Fill, order, and overflow: push Logic 1, CMP 2, Shift 3, Arith 4 with Out_Ready = 0.
  - Full = 1, Count = 4.
  - A fifth push of 5: Overflow = 1 and Count stays 4.
  - Draining yields 1/01, 2/10, 3/11, 4/00 in order.
- Full with simultaneous push and pop: push 9 while popping.
  - Count stays 4 and Overflow stays 0.
  - Entry 9 emerges last; pointer wrap is exercised.
- Multi-flag: Logic_Flag and SHIFT_Flag high together with values 7 and 8.
  - Only 7 is queued, tag 01.
  - Multi_Flag_Err = 1 and persists until RST.
- Reset mid-stream with 3 queued entries: the cycle after RST shows Count = 0, Out_Valid = 0, Overflow = 0, and no stale data appears after further pushes.
